lsu_data_mem_responder: RTL

Responder end of the core's load/store data path. It accepts RV32I load and store requests from the LSU over a valid/ready request channel and services them against an internal word-organised data array. It performs byte-lane steering, sign or zero extension, and alignment and range checks. It returns one response per request on a valid/ready response channel, after a programmable number of wait states.

---
 rtl/lsu_data_mem_responder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_data_mem_responder.sv
// Purpose: LSU data-memory responder; services RV32I loads/stores against a word array with lane steering and fault checks.
// Latency: accept at edge N -> rsp_valid high after edge N+1+WAIT_CYCLES; one request in flight at a time.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready, next accept one cycle later.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake; req_we, req_addr, req_funct3, req_wdata captured on accept
//   rsp_valid/rsp_ready         response handshake; rsp_rdata (extended load data), rsp_err (fault flag)
module lsu_data_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Decode and fault checks on the captured request
    // ------------------------------------------------------------------
    logic [1:0]    size_code;     // 0 byte, 1 half, 2 word (3 only for illegal funct3)
    logic          illegal;
    logic          misaligned;
    logic          out_of_range;
    logic          fault;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_val;
    logic [3:0]    be;
    logic [31:0]   wsh;
    logic [31:0]   merged;
    logic          access;
    logic          mem_we;

    always_comb begin
        size_code    = funct3_q[1:0];
        illegal      = we_q ? (funct3_q > 3'd2)
                            : ((funct3_q == 3'd3) || (funct3_q[2:1] == 2'b11));
        misaligned   = ((size_code == 2'd1) && addr_q[0]) ||
                       ((size_code == 2'd2) && (addr_q[1:0] != 2'b00));
        out_of_range = (addr_q[31:2] >= 30'(DEPTH));
        fault        = illegal | misaligned | out_of_range;
        idx          = addr_q[2 +: AW];
        rd_word      = mem_q[idx];
    end

    // Load path: pick the addressed lane(s) then extend according to funct3
    always_comb begin
        rd_byte  = rd_word[{addr_q[1:0], 3'b000} +: 8];
        rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = 32'd0;
        case (funct3_q)
            3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
            3'd2:    load_val = rd_word;
            3'd4:    load_val = {24'd0, rd_byte};
            3'd5:    load_val = {16'd0, rd_half};
            default: load_val = 32'd0;
        endcase
    end

    // Store path: replicate the source bytes across the word and merge
    // only the enabled lanes into the existing contents.
    always_comb begin
        be  = 4'b1111;
        wsh = wdata_q;
        case (size_code)
            2'd0: begin
                be  = 4'b0001 << addr_q[1:0];
                wsh = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                be  = addr_q[1] ? 4'b1100 : 4'b0011;
                wsh = {2{wdata_q[15:0]}};
            end
            default: begin
                be  = 4'b1111;
                wsh = wdata_q;
            end
        endcase
        merged = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wsh[8*i +: 8];
            end
        end
    end

    // The array is touched only on the WAIT exit edge, so a reset during
    // WAIT drops a store before it has any effect.
    assign access = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign mem_we = access && we_q && !fault;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= merged;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        funct3_d  = funct3_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    cnt_d    = 4'(WAIT_CYCLES);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = (fault || we_q) ? 32'd0 : load_val;
                    err_d   = fault;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
